// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one combinational 32-bit barrel shifter; each port
// has a one-entry registered response buffer, so accept-to-result is one cycle.
module shift_arbiter #(
  parameter bit FAIR      = 1'b1,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_dir,
  input  logic        req0_type,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_dir,
  input  logic        req1_type,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_data,
  output logic        busy
);

  function automatic logic [31:0] barrel_shift(input logic [31:0] a, input logic [4:0] shamt,
                                               input logic dir, input logic arith);
    logic [31:0] r;
    if (dir == 1'b0) begin
      r = a << shamt;
    end else if (arith == 1'b1) begin
      r = $unsigned($signed(a) >>> shamt);
    end else begin
      r = a >> shamt;
    end
    return r;
  endfunction

  logic        resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
  logic [31:0] resp0_data_q, resp0_data_d, resp1_data_q, resp1_data_d;
  logic        prio_q, prio_d, busy_q, busy_d;
  logic        cand0, cand1, grant0, grant1;
  logic [31:0] op_a, shift_res;
  logic [4:0]  op_shamt;
  logic        op_dir, op_type;

  // Arbitration: a draining buffer counts as free, so a port can refill it on the same edge
  always_comb begin
    cand0  = req0_valid & (~resp0_valid_q | resp0_ready);
    cand1  = req1_valid & (~resp1_valid_q | resp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (cand0 && cand1) begin
      if (FAIR && prio_q) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = cand0;
      grant1 = cand1;
    end
    if (grant1) begin
      op_a     = req1_a;
      op_shamt = req1_shamt;
      op_dir   = req1_dir;
      op_type  = req1_type;
    end else begin
      op_a     = req0_a;
      op_shamt = req0_shamt;
      op_dir   = req0_dir;
      op_type  = req0_type;
    end
    shift_res = barrel_shift(op_a, op_shamt, op_dir, op_type);
  end

  assign req0_ready = grant0 & ~reset;
  assign req1_ready = grant1 & ~reset;

  // Next state of response buffers, priority pointer and busy flag
  always_comb begin
    resp0_valid_d = resp0_valid_q;
    resp0_data_d  = resp0_data_q;
    resp1_valid_d = resp1_valid_q;
    resp1_data_d  = resp1_data_q;
    prio_d        = prio_q;
    if (req0_valid && req0_ready) begin
      resp0_valid_d = 1'b1;
      resp0_data_d  = shift_res;
    end else if (resp0_valid_q && resp0_ready) begin
      resp0_valid_d = 1'b0;
    end else begin
      resp0_valid_d = resp0_valid_q;
    end
    if (req1_valid && req1_ready) begin
      resp1_valid_d = 1'b1;
      resp1_data_d  = shift_res;
    end else if (resp1_valid_q && resp1_ready) begin
      resp1_valid_d = 1'b0;
    end else begin
      resp1_valid_d = resp1_valid_q;
    end
    if (FAIR && grant0) begin
      prio_d = 1'b1;
    end else if (FAIR && grant1) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
    busy_d = resp0_valid_d | resp1_valid_d;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      resp0_valid_q <= 1'b0;
      resp0_data_q  <= 32'd0;
      resp1_valid_q <= 1'b0;
      resp1_data_q  <= 32'd0;
      prio_q        <= INIT_PRIO;
      busy_q        <= 1'b0;
    end else begin
      resp0_valid_q <= resp0_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_valid_q <= resp1_valid_d;
      resp1_data_q  <= resp1_data_d;
      prio_q        <= prio_d;
      busy_q        <= busy_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_data  = resp1_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic checked
// every cycle against a behavioural model; a second FAIR=0 instance covers fixed priority.
module tb_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req0_ready, req0_dir, req0_type, resp0_valid, resp0_ready;
  logic        req1_valid, req1_ready, req1_dir, req1_type, resp1_valid, resp1_ready;
  logic [31:0] req0_a, req1_a, resp0_data, resp1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        busy;

  logic        f_req0_valid, f_req0_ready, f_resp0_valid, f_req1_valid, f_req1_ready, f_resp1_valid;
  logic [31:0] f_resp0_data, f_resp1_data;
  logic        f_busy;

  int n_vec = 0;
  int n_err = 0;

  bit          exp_valid [2];
  logic [31:0] exp_data  [2];
  bit          exp_prio;
  bit          acc0, acc1;

  shift_arbiter #(.FAIR(1'b1), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_shamt(req0_shamt),
    .req0_dir(req0_dir), .req0_type(req0_type),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_shamt(req1_shamt),
    .req1_dir(req1_dir), .req1_type(req1_type),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .busy(busy)
  );

  shift_arbiter #(.FAIR(1'b0), .INIT_PRIO(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(32'h0000_0003), .req0_shamt(5'd1),
    .req0_dir(1'b0), .req0_type(1'b0),
    .resp0_valid(f_resp0_valid), .resp0_ready(1'b1), .resp0_data(f_resp0_data),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(32'h0000_0005), .req1_shamt(5'd2),
    .req1_dir(1'b0), .req1_type(1'b0),
    .resp1_valid(f_resp1_valid), .resp1_ready(1'b1), .resp1_data(f_resp1_data),
    .busy(f_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shift as integer arithmetic: multiply/divide by 2**sh, floor division for negative values
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                            input logic right, input logic arith);
    logic [63:0] pow, w;
    logic [31:0] p32;
    pow = 64'd1 << sh;
    p32 = pow[31:0];
    if (!right) begin
      w = {32'd0, a} * pow;
      return w[31:0];
    end
    if (arith && a[31]) return ~((~a) / p32);
    return a / p32;
  endfunction

  // Called just after negedge with inputs set: checks outputs, then advances the model over one edge
  task automatic tick();
    int cand[$];
    int winner;
    logic [31:0] res0, res1;
    bit rr0, rr1, rst;
    #1;
    if (req0_valid && (!exp_valid[0] || resp0_ready)) cand.push_back(0);
    if (req1_valid && (!exp_valid[1] || resp1_ready)) cand.push_back(1);
    winner = -1;
    if (cand.size() == 1) winner = cand[0];
    else if (cand.size() == 2) winner = int'(exp_prio);
    rst = reset;
    check_eq("req0_ready", 32'(req0_ready), 32'(!rst && winner == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(!rst && winner == 1));
    check_eq("resp0_valid", 32'(resp0_valid), 32'(exp_valid[0]));
    check_eq("resp1_valid", 32'(resp1_valid), 32'(exp_valid[1]));
    check_eq("resp0_data", resp0_data, exp_data[0]);
    check_eq("resp1_data", resp1_data, exp_data[1]);
    check_eq("busy", 32'(busy), 32'(exp_valid[0] | exp_valid[1]));
    res0 = ref_shift(req0_a, req0_shamt, req0_dir, req0_type);
    res1 = ref_shift(req1_a, req1_shamt, req1_dir, req1_type);
    rr0 = resp0_ready;
    rr1 = resp1_ready;
    @(posedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      exp_valid = '{1'b0, 1'b0};
      exp_data  = '{32'd0, 32'd0};
      exp_prio  = 1'b0;
    end else begin
      if (winner == 0) begin exp_valid[0] = 1'b1; exp_data[0] = res0; end
      else if (exp_valid[0] && rr0) exp_valid[0] = 1'b0;
      if (winner == 1) begin exp_valid[1] = 1'b1; exp_data[1] = res1; end
      else if (exp_valid[1] && rr1) exp_valid[1] = 1'b0;
      if (winner >= 0) exp_prio = (winner == 0);
      acc0 = (winner == 0);
      acc1 = (winner == 1);
    end
    @(negedge clk);
  endtask

  task automatic rand_drive();
    if (!req0_valid || acc0) begin
      req0_valid = ($urandom_range(3) != 0);
      req0_a     = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
      req0_shamt = 5'($urandom_range(31));
      req0_dir   = 1'($urandom_range(1));
      req0_type  = 1'($urandom_range(1));
    end
    if (!req1_valid || acc1) begin
      req1_valid = ($urandom_range(3) != 0);
      req1_a     = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      req1_shamt = 5'($urandom_range(31));
      req1_dir   = 1'($urandom_range(1));
      req1_type  = 1'($urandom_range(1));
    end
    resp0_ready = ($urandom_range(2) != 0);
    resp1_ready = ($urandom_range(2) != 0);
    reset       = ($urandom_range(60) == 0);
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [4:0] sh,
                         input logic dir, input logic typ);
    if (p == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_shamt = sh; req0_dir = dir; req0_type = typ;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_shamt = sh; req1_dir = dir; req1_type = typ;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_shamt = 5'd0; req0_dir = 1'b0; req0_type = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_shamt = 5'd0; req1_dir = 1'b0; req1_type = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    exp_valid = '{1'b0, 1'b0};
    exp_data  = '{32'd0, 32'd0};
    exp_prio  = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Requests presented during reset must not be accepted
    set_req(0, 32'h1234_5678, 5'd3, 1'b0, 1'b0);
    set_req(1, 32'h8765_4321, 5'd3, 1'b1, 1'b1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_rv0", 32'(resp0_valid), 32'd0);

    set_req(0, 32'h8000_0000, 5'd4, 1'b1, 1'b1);
    #1 check_eq("sra_ready", 32'(req0_ready), 32'd1);
    tick();
    check_eq("sra_data", resp0_data, 32'hF800_0000);
    req0_type = 1'b0;
    tick();
    check_eq("srl_data", resp0_data, 32'h0800_0000);
    req0_valid = 1'b0;

    set_req(1, 32'h0000_0001, 5'd31, 1'b0, 1'b0);
    tick();
    check_eq("sll31_data", resp1_data, 32'h8000_0000);
    set_req(1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1);
    tick();
    check_eq("sh0_data", resp1_data, 32'hDEAD_BEEF);
    req1_valid = 1'b0;

    // Contention: FAIR instance alternates, fixed-priority instance always picks port 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 32'h0000_00F0, 5'd2, 1'b1, 1'b0);
    set_req(1, 32'h0000_000F, 5'd2, 1'b0, 1'b0);
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_grant0", 32'(req0_ready), 32'(i % 2 == 0));
      check_eq("rr_grant1", 32'(req1_ready), 32'(i % 2 == 1));
      check_eq("fp_grant0", 32'(f_req0_ready), 32'd1);
      check_eq("fp_grant1", 32'(f_req1_ready), 32'd0);
      tick();
    end
    check_eq("fp_rv1", 32'(f_resp1_valid), 32'd0);
    check_eq("fp_data0", f_resp0_data, 32'h0000_0006);
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Backpressure on port 0 while port 1 streams
    resp0_ready = 1'b0;
    set_req(0, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
    tick();
    set_req(0, 32'h0000_0003, 5'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_req(1, 32'h100 << i, 5'd1, 1'b1, 1'b0);
      #1;
      check_eq("bp_ready0", 32'(req0_ready), 32'd0);
      check_eq("bp_ready1", 32'(req1_ready), 32'd1);
      tick();
      check_eq("bp_hold0", resp0_data, 32'h0000_0002);
      check_eq("bp_data1", resp1_data, 32'h80 << i);
    end
    resp0_ready = 1'b1;
    #1 check_eq("bp_release", 32'(req0_ready), 32'd1);
    tick();
    check_eq("b2b_valid0", 32'(resp0_valid), 32'd1);
    check_eq("b2b_data0", resp0_data, 32'h0000_000C);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Reset right after a port 1 accept discards the buffered result
    resp1_ready = 1'b0;
    set_req(1, 32'h0000_0005, 5'd1, 1'b0, 1'b0);
    tick();
    req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("rst_rv1", 32'(resp1_valid), 32'd0);
    check_eq("rst_rd1", resp1_data, 32'd0);
    reset = 1'b0;
    resp1_ready = 1'b1;
    tick();
    check_eq("post_rst_rv1", 32'(resp1_valid), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      rand_drive();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 32-bit barrel shifter (logical/arithmetic, left/right, 0-31 shift) between two requesters: port 0 (EX-stage ALU) and port 1 (multiply/divide sequencer).
- Each requester has its own valid/ready request channel and its own registered response channel.
- Arbitration is round-robin, or fixed-priority when configured.
- Sits between the EX stage and the shift datapath; the shifter itself is instantiated inside this block.

Parameters:
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- INIT_PRIO, 0, port holding priority after reset (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when valid&ready
- req0_a  in  32  port 0 operand
- req0_shamt  in  5  port 0 shift amount
- req0_dir  in  1  port 0 direction: 0 left, 1 right
- req0_type  in  1  port 0 type: 0 logical, 1 arithmetic
- resp0_valid  out  1  port 0 result valid
- resp0_ready  in  1  port 0 consumer ready
- resp0_data  out  32  port 0 result
- req1_valid, req1_ready, req1_a, req1_shamt, req1_dir, req1_type, resp1_valid, resp1_ready, resp1_data: identical to port 0, for port 1
- busy  out  1  high when either response buffer is occupied

Behaviour:
- Reset (synchronous, checked on clk edge):
  - resp0_valid = resp1_valid = 0; resp0_data = resp1_data = 0.
  - prio = INIT_PRIO.
  - req0_ready = req1_ready = 0 while reset is high (combinationally gated).
- Response buffer: one 32-bit entry per port with a valid bit (resp_valid).
- Eligibility per port i: elig_i = !resp_valid_i | resp_ready_i. A buffer being drained this cycle may be refilled in the same cycle.
- Grant, combinational, one port per cycle:
  - Only one port has valid & elig: that port is granted.
  - Both have valid & elig: FAIR=1 grants the port named by prio; FAIR=0 grants port 0.
  - Neither: no grant.
- Handshake rules:
  - reqN_ready = grant_N & !reset.
  - Requester must hold operands and valid stable until ready.
  - ready does not depend on the requester's own operands.
- Shifter operand mux: selects the granted port's a/shamt/dir/type; defaults to port 0 when there is no grant.
- Shift semantics:
  - Left: zero-fill.
  - Right logical: zero-fill.
  - Right arithmetic: fill with a[31].
  - Left arithmetic behaves as left logical.
  - shamt = 0 passes a unchanged.
- Latency: exactly 1 cycle. Accept at edge T means resp_valid_i = 1 and resp_data_i = result after edge T; visible in cycle T+1.
- Response buffer update per port each edge:
  - accept: load result, valid = 1.
  - else if resp_valid & resp_ready: valid = 0; data holds its old value.
  - else: hold.
  - Simultaneous drain and accept on the same port: load the new result; valid stays 1, giving back-to-back throughput of 1 per cycle per port.
- Priority update (FAIR=1 only):
  - On a grant to port g, prio becomes !g.
  - No grant: prio holds.
  - A lone requester therefore never stalls, and after it is served the other port holds priority.
- Starvation bound: with FAIR=1, a continuously valid and eligible port is granted within 2 cycles.
- Backpressure: a port whose buffer is full and not draining is not eligible; the other port may use the shifter every cycle meanwhile.
- busy = resp0_valid | resp1_valid.
- Reset mid-operation: pending buffers are discarded (valid cleared); any request presented during reset is not accepted.

Test Plan:
- Reset then idle: after reset, all resp_valid = 0, resp_data = 0, both ready = 0 during reset; after reset with no requests, busy = 0.
- Single port 0 request, a=0x80000000, shamt=4, dir=1, type=1, resp0_ready=1 -> req0_ready=1 in the same cycle; next cycle resp0_valid=1, resp0_data=0xF8000000. Repeat with type=0 -> 0x08000000.
- Port 1 request, a=0x00000001, shamt=31, dir=0 -> resp1_data=0x80000000. Then shamt=0, a=0xDEADBEEF -> 0xDEADBEEF.
- Both ports valid every cycle, FAIR=1, INIT_PRIO=0, both resp_ready=1 -> grants alternate 0,1,0,1 over 4 cycles. With FAIR=0, port 0 is granted all 4 cycles and port 1 never.
- Backpressure: resp0_ready=0 with a full buffer while port 0 keeps requesting -> req0_ready=0 and resp0_data is held. Port 1 is still served each cycle. Raising resp0_ready -> drain and new accept on the same edge, resp0_valid stays 1.
- Reset asserted one cycle after a port 1 accept -> resp1_valid=0 after the reset edge, and that result is never presented.
